melody_sequencer: RTL and testbench

Consumer of the play/pause level. While `play` is 1 it steps through a melody stored in an external synchronous ROM. Each ROM word gives a note and a duration in beats. The block drives a 1-bit square-wave `audio` output at the note pitch, and freezes everything in place while paused.

---
 rtl/melody_pkg.sv | 48 ++++
 rtl/tone_gen.sv | 33 +++
 rtl/melody_sequencer.sv | 102 ++++++++++
 tb/tb_melody_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/melody_pkg.sv
// Shared types and constants for the melody sequencer: note codes, the
// pitch table and the sequencer state encoding.
package melody_pkg;

   localparam int NOTE_W = 4;
   localparam int DUR_W  = 4;
   localparam int HP_W   = 17;

   localparam logic [NOTE_W-1:0] REST = 4'd0;
   localparam logic [NOTE_W-1:0] C4   = 4'd1;
   localparam logic [NOTE_W-1:0] CS4  = 4'd2;
   localparam logic [NOTE_W-1:0] D4   = 4'd3;
   localparam logic [NOTE_W-1:0] DS4  = 4'd4;
   localparam logic [NOTE_W-1:0] E4   = 4'd5;
   localparam logic [NOTE_W-1:0] F4   = 4'd6;
   localparam logic [NOTE_W-1:0] FS4  = 4'd7;
   localparam logic [NOTE_W-1:0] G4   = 4'd8;
   localparam logic [NOTE_W-1:0] GS4  = 4'd9;
   localparam logic [NOTE_W-1:0] A4   = 4'd10;
   localparam logic [NOTE_W-1:0] AS4  = 4'd11;
   localparam logic [NOTE_W-1:0] B4   = 4'd12;

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, HALT} state_t;

   // Half-period in 50 MHz clk cycles; rests (0, 13..15) map to 0.
   function automatic logic [HP_W-1:0] note_half_period(input logic [NOTE_W-1:0] code);
      case (code)
         C4:      return 17'd95557;
         CS4:     return 17'd90193;
         D4:      return 17'd85131;
         DS4:     return 17'd80354;
         E4:      return 17'd75843;
         F4:      return 17'd71586;
         FS4:     return 17'd67568;
         G4:      return 17'd63776;
         GS4:     return 17'd60197;
         A4:      return 17'd56818;
         AS4:     return 17'd53629;
         B4:      return 17'd50619;
         default: return '0;
      endcase
   endfunction

   function automatic logic is_rest(input logic [NOTE_W-1:0] code);
      return (code == REST) || (code > B4);
   endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: toggles its output every `half` enabled cycles.
// Holding enable low freezes the phase; clear restarts it from a low output.
module tone_gen
   import melody_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            enable,
   input  logic            clear,
   input  logic [HP_W-1:0] half,
   output logic            wave
);

   logic [HP_W-1:0] tone_cnt_reg;
   logic            wave_reg;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         tone_cnt_reg <= '0;
         wave_reg     <= 1'b0;
      end else if (enable) begin
         if (tone_cnt_reg == half - HP_W'(1)) begin
            tone_cnt_reg <= '0;
            wave_reg     <= ~wave_reg;
         end else begin
            tone_cnt_reg <= tone_cnt_reg + HP_W'(1);
         end
      end
   end

   assign wave = wave_reg;

endmodule

// File: rtl/melody_sequencer.sv
// Steps through a melody in an external synchronous ROM while play is high,
// producing a square wave per note; pausing freezes position and tone phase.
module melody_sequencer
   import melody_pkg::*;
#(
   parameter int ADDR_W      = 4,
   parameter int BEAT_CYCLES = 12_500_000,
   parameter int DIV_SHIFT   = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              play,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   output logic              audio,
   output logic [3:0]        cur_note,
   output logic              beat_pulse,
   output logic              playing
);

   localparam int BC_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
   localparam logic [BC_W-1:0] BEAT_LAST = BC_W'(BEAT_CYCLES - 1);

   state_t              state_reg;
   logic [ADDR_W-1:0]   rom_addr_reg;
   logic [NOTE_W-1:0]   cur_note_reg;
   logic [DUR_W-1:0]    beats_left_reg;
   logic [BC_W-1:0]     beat_cnt_reg;
   logic                beat_pulse_reg;
   logic                active;
   logic                tone_wave;
   logic [HP_W-1:0]     half;

   assign active = (state_reg == PLAY) && play;
   assign half   = note_half_period(cur_note_reg) >> DIV_SHIFT;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         rom_addr_reg   <= '0;
         cur_note_reg   <= REST;
         beats_left_reg <= '0;
         beat_cnt_reg   <= '0;
         beat_pulse_reg <= 1'b0;
      end else begin
         beat_pulse_reg <= 1'b0;
         case (state_reg)
            IDLE: if (play) state_reg <= FETCH;
            FETCH: state_reg <= LOAD;
            LOAD: begin
               cur_note_reg   <= rom_data[7:4];
               beats_left_reg <= rom_data[3:0];
               if (rom_data[3:0] == '0) begin
                  // Zero duration marks end of song; at address 0 the song is empty.
                  if (rom_addr_reg == '0) begin
                     state_reg <= HALT;
                  end else begin
                     rom_addr_reg <= '0;
                     state_reg    <= FETCH;
                  end
               end else begin
                  beat_cnt_reg <= '0;
                  state_reg    <= PLAY;
               end
            end
            PLAY: begin
               if (play) begin
                  if (beat_cnt_reg == BEAT_LAST) begin
                     beat_cnt_reg   <= '0;
                     beat_pulse_reg <= 1'b1;
                     beats_left_reg <= beats_left_reg - DUR_W'(1);
                     if (beats_left_reg == DUR_W'(1)) begin
                        rom_addr_reg <= rom_addr_reg + ADDR_W'(1);
                        state_reg    <= FETCH;
                     end
                  end else begin
                     beat_cnt_reg <= beat_cnt_reg + BC_W'(1);
                  end
               end
            end
            HALT: state_reg <= HALT;
            default: state_reg <= IDLE;
         endcase
      end
   end

   tone_gen u_tone_gen (
      .clk    (clk),
      .reset  (reset),
      .enable (active),
      .clear  (state_reg == LOAD),
      .half   (half),
      .wave   (tone_wave)
   );

   assign audio      = tone_wave && active && !is_rest(cur_note_reg);
   assign rom_addr   = rom_addr_reg;
   assign cur_note   = cur_note_reg;
   assign beat_pulse = beat_pulse_reg;
   assign playing    = active;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with a small synchronous ROM model,
// using a fast beat and pitch divider so whole notes fit in a few hundred cycles.
module tb_melody_sequencer;

   localparam int ADDR_W = 4;
   localparam int BEAT   = 200;
   localparam int SHIFT  = 10;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              play = 1'b0;
   logic [ADDR_W-1:0] rom_addr;
   logic [7:0]        rom_data;
   logic              audio;
   logic [3:0]        cur_note;
   logic              beat_pulse;
   logic              playing;
   logic [7:0]        rom [16];

   int err_cnt = 0;
   int chk_cnt = 0;

   melody_sequencer #(
      .ADDR_W      (ADDR_W),
      .BEAT_CYCLES (BEAT),
      .DIV_SHIFT   (SHIFT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .play       (play),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .audio      (audio),
      .cur_note   (cur_note),
      .beat_pulse (beat_pulse),
      .playing    (playing)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom[rom_addr];

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input int got, input int exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end else begin
         $display("check %s: got=%0d ok", tag, got);
      end
   endtask

   // Bounded wait for the first active PLAY cycle; reports cycles taken.
   task automatic wait_playing(input string tag, input int exp_ticks);
      int t;
      t = 0;
      while (playing !== 1'b1 && t < 20) begin
         tick(1);
         t++;
      end
      check(tag, t, exp_ticks);
   endtask

   // Walks active PLAY cycles n0..n1 against the hand model:
   // audio = floor((n-1)/half) odd for tones, 0 for rests; one pulse at pulse_at.
   task automatic run_note(input int n0, input int n1, input int half, input bit tone,
                           input int pulse_at, output int bad, output int first_rise);
      bad = 0;
      first_rise = 0;
      for (int n = n0; n <= n1; n++) begin
         logic ea;
         ea = tone ? (((n - 1) / half) % 2 == 1) : 1'b0;
         if (audio !== ea) bad++;
         if (beat_pulse !== (n == pulse_at)) bad++;
         if (playing !== 1'b1) bad++;
         if (audio === 1'b1 && first_rise == 0) first_rise = n;
         tick(1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int bad;
      int fr;
      for (int i = 0; i < 16; i++) rom[i] = 8'h00;
      rom[0] = 8'hA2;
      rom[1] = 8'h01;
      rom[2] = 8'h51;
      rom[3] = 8'h00;

      reset = 1'b1;
      play  = 1'b0;
      tick(2);
      reset = 1'b0;
      check("rst_audio", audio, 0);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_cur_note", cur_note, 0);
      check("rst_beat_pulse", beat_pulse, 0);
      check("rst_playing", playing, 0);

      bad = 0;
      repeat (1000) begin
         tick(1);
         if (audio !== 1'b0 || beat_pulse !== 1'b0 || playing !== 1'b0 || rom_addr !== 4'd0) bad++;
      end
      check("idle_1000", bad, 0);

      play = 1'b1;
      wait_playing("start_latency", 3);
      check("a4_cur_note", cur_note, 10);
      run_note(1, 400, 55, 1'b1, 201, bad, fr);
      check("a4_wave", bad, 0);
      check("a4_first_rise", fr, 56);
      check("a4_end_pulse", beat_pulse, 1);
      check("a4_end_addr", rom_addr, 1);
      check("a4_end_playing", playing, 0);

      wait_playing("rest_gap", 2);
      check("rest_cur_note", cur_note, 0);
      run_note(1, 200, 55, 1'b0, 0, bad, fr);
      check("rest_wave", bad, 0);
      check("rest_first_rise", fr, 0);
      check("rest_end_pulse", beat_pulse, 1);
      check("rest_end_addr", rom_addr, 2);

      wait_playing("e4_gap", 2);
      check("e4_cur_note", cur_note, 5);
      run_note(1, 200, 74, 1'b1, 0, bad, fr);
      check("e4_wave", bad, 0);
      check("e4_first_rise", fr, 75);
      check("e4_end_addr", rom_addr, 3);

      tick(1);
      check("marker_load_addr", rom_addr, 3);
      tick(1);
      check("marker_refetch_addr", rom_addr, 0);
      wait_playing("marker_gap", 2);
      check("replay_cur_note", cur_note, 10);

      run_note(1, 100, 55, 1'b1, 0, bad, fr);
      check("pre_pause_wave", bad, 0);
      check("pre_pause_audio", audio, 1);
      play = 1'b0;
      bad = 0;
      repeat (500) begin
         tick(1);
         if (audio !== 1'b0 || beat_pulse !== 1'b0 || rom_addr !== 4'd0 || playing !== 1'b0) bad++;
      end
      check("pause_frozen", bad, 0);
      play = 1'b1;
      #1;
      check("resume_phase", audio, 1);
      run_note(101, 400, 55, 1'b1, 201, bad, fr);
      check("resume_wave", bad, 0);
      check("resume_end_addr", rom_addr, 1);
      check("resume_end_pulse", beat_pulse, 1);

      wait_playing("rest2_gap", 2);
      tick(50);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("midnote_rst_playing", playing, 0);
      check("midnote_rst_addr", rom_addr, 0);
      check("midnote_rst_audio", audio, 0);
      check("midnote_rst_note", cur_note, 0);
      wait_playing("post_reset_latency", 3);
      check("post_reset_note", cur_note, 10);

      rom[0] = 8'h00;
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(3);
      rom[0] = 8'hA2;
      bad = 0;
      repeat (300) begin
         if (audio !== 1'b0 || beat_pulse !== 1'b0 || rom_addr !== 4'd0 || playing !== 1'b0) bad++;
         tick(1);
      end
      check("halt_stuck", bad, 0);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      wait_playing("halt_reset_restart", 3);
      check("halt_restart_note", cur_note, 10);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
